// File: rtl/deinter_pkg.sv
// Shared constants and FSM encoding for the ping-pong SRAM deinterleaver scheduler.
package deinter_pkg;

    localparam int ROWS     = 12;
    localparam int COLS     = 128;
    localparam int BLK      = ROWS * COLS;
    localparam int AW       = 14;
    localparam int BANK_BIT = 11;
    localparam int ROW_W    = 4;
    localparam int COL_W    = 7;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/deinter_sram_sched_if.sv
// Symbol-in / SRAM-control bundle between the symbol source and the scheduler.
interface deinter_sram_sched_if #(
    parameter int AW = deinter_pkg::AW
);

    logic          en_in;
    logic [AW-1:0] ADDR;
    logic          NCE;
    logic          NWRT;
    logic          en_out;
    logic          err;

    modport master (
        output en_in,
        input  ADDR, NCE, NWRT, en_out, err
    );

    modport slave (
        input  en_in,
        output ADDR, NCE, NWRT, en_out, err
    );

endinterface

// File: rtl/deinter_rd_agen.sv
// Column-major read address generator: row runs fastest, column steps on row wrap.
module deinter_rd_agen #(
    parameter int ROWS = deinter_pkg::ROWS,
    parameter int COLS = deinter_pkg::COLS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            advance,
    output logic                            last,
    output logic [deinter_pkg::BANK_BIT-1:0] off
);

    localparam int RW = deinter_pkg::ROW_W;
    localparam int CW = deinter_pkg::COL_W;

    logic [RW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic          row_wrap;
    logic          col_wrap;

    assign row_wrap = (row_reg == RW'(ROWS - 1));
    assign col_wrap = (col_reg == CW'(COLS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (clear) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (advance) begin
            if (row_wrap) begin
                row_reg <= '0;
                col_reg <= col_wrap ? '0 : col_reg + CW'(1);
            end else begin
                row_reg <= row_reg + RW'(1);
            end
        end
    end

    assign last = row_wrap && col_wrap;
    assign off  = {row_reg, col_reg};

endmodule

// File: rtl/deinter_sram_sched.sv
// Single-port SRAM scheduler for a two-bank block deinterleaver; writes always win the port.
module deinter_sram_sched #(
    parameter int ROWS = deinter_pkg::ROWS,
    parameter int COLS = deinter_pkg::COLS,
    parameter int AW   = deinter_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    deinter_sram_sched_if.slave  bus
);

    typedef deinter_pkg::state_t state_t;

    localparam int BW  = deinter_pkg::BANK_BIT;
    localparam int BLK = ROWS * COLS;
    localparam int PAD = AW - BW - 1;

    state_t        state_reg;
    state_t        state_next;
    logic          bank_w_reg;
    logic          bank_r_reg;
    logic [BW-1:0] wcnt_reg;
    logic          en_in_prev_reg;
    logic          err_reg;
    logic          en_out_reg;
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] addr_next;

    logic          wr_acc;
    logic          rd_acc;
    logic          wr_last;
    logic          rd_last;
    logic          rd_last_cell;
    logic          swap;
    logic [BW-1:0] rd_off;

    // Reset gates the combinational access path so en_in is ignored while rst is low.
    assign wr_acc  = rst && bus.en_in && (state_reg != deinter_pkg::ST_HOLD);
    assign rd_acc  = rst && !bus.en_in &&
                     ((state_reg == deinter_pkg::ST_RUN) || (state_reg == deinter_pkg::ST_HOLD));
    assign wr_last = wr_acc && (wcnt_reg == BW'(BLK - 1));
    assign rd_last = rd_acc && rd_last_cell;

    deinter_rd_agen #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rd_agen (
        .clk     (clk),
        .rst     (rst),
        .clear   (swap),
        .advance (rd_acc),
        .last    (rd_last_cell),
        .off     (rd_off)
    );

    always_comb begin
        state_next = state_reg;
        swap       = 1'b0;
        case (state_reg)
            deinter_pkg::ST_FILL: begin
                if (wr_last) begin
                    swap       = 1'b1;
                    state_next = deinter_pkg::ST_RUN;
                end
            end
            deinter_pkg::ST_RUN: begin
                if (rd_last)
                    state_next = deinter_pkg::ST_WAIT;
                else if (wr_last)
                    state_next = deinter_pkg::ST_HOLD;
            end
            deinter_pkg::ST_WAIT: begin
                if (wr_last) begin
                    swap       = 1'b1;
                    state_next = deinter_pkg::ST_RUN;
                end
            end
            deinter_pkg::ST_HOLD: begin
                if (rd_last) begin
                    swap       = 1'b1;
                    state_next = deinter_pkg::ST_RUN;
                end
            end
            default: state_next = deinter_pkg::ST_FILL;
        endcase
    end

    always_comb begin
        addr_next = addr_reg;
        if (wr_acc)
            addr_next = {{PAD{1'b0}}, bank_w_reg, wcnt_reg};
        else if (rd_acc)
            addr_next = {{PAD{1'b0}}, bank_r_reg, rd_off};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= deinter_pkg::ST_FILL;
            bank_w_reg     <= 1'b0;
            bank_r_reg     <= 1'b1;
            wcnt_reg       <= '0;
            en_in_prev_reg <= 1'b0;
            err_reg        <= 1'b0;
            en_out_reg     <= 1'b0;
            addr_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            en_in_prev_reg <= bus.en_in;
            en_out_reg     <= rd_acc;
            addr_reg       <= addr_next;
            if (swap) begin
                bank_w_reg <= ~bank_w_reg;
                bank_r_reg <= ~bank_r_reg;
            end
            if (swap || wr_last)
                wcnt_reg <= '0;
            else if (wr_acc)
                wcnt_reg <= wcnt_reg + BW'(1);
            // Sticky: back-to-back input symbols, or a new block overrunning unread data.
            if ((bus.en_in && en_in_prev_reg) ||
                ((state_next == deinter_pkg::ST_HOLD) && (state_reg != deinter_pkg::ST_HOLD)))
                err_reg <= 1'b1;
        end
    end

    assign bus.ADDR   = addr_next;
    assign bus.NCE    = ~(wr_acc | rd_acc);
    assign bus.NWRT   = ~wr_acc;
    assign bus.en_out = en_out_reg;
    assign bus.err    = err_reg;

endmodule

// File: tb/tb_deinter_sram_sched.sv
// Scoreboard bench: stimulus queues expected SRAM accesses and output data, a negedge monitor checks them.
module tb_deinter_sram_sched;

    import deinter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    deinter_sram_sched_if #(.AW(AW)) bus ();

    deinter_sram_sched #(
        .ROWS (ROWS),
        .COLS (COLS),
        .AW   (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] din;
    logic [15:0] dout;
    logic [15:0] mem [0:4095];

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.NCE === 1'b0) begin
            if (bus.NWRT === 1'b0)
                mem[bus.ADDR[11:0]] <= din;
            else
                dout <= mem[bus.ADDR[11:0]];
        end
    end

    int total = 0;
    int bad   = 0;
    int exp_w[$];
    int exp_ra[$];
    int exp_rd[$];
    int last_raddr = -1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.NCE === 1'b0 && bus.NWRT === 1'b0) begin
                if (exp_w.size() == 0) chk("unexpected_write", int'(bus.ADDR), -1);
                else                   chk("wr_addr", int'(bus.ADDR), exp_w.pop_front());
            end
            if (bus.NCE === 1'b0 && bus.NWRT === 1'b1) begin
                last_raddr = int'(bus.ADDR);
                if (exp_ra.size() == 0) chk("unexpected_read", int'(bus.ADDR), -1);
                else                    chk("rd_addr", int'(bus.ADDR), exp_ra.pop_front());
            end
            if (bus.en_out === 1'b1) begin
                if (exp_rd.size() == 0) chk("unexpected_en_out", int'(dout), -1);
                else begin
                    int e;
                    e = exp_rd.pop_front();
                    $display("out data=%0d expected=%0d", dout, e);
                    chk("rd_data", int'(dout), e);
                end
            end
        end
    end

    task automatic wr(input int bank, input int idx, input int data);
        exp_w.push_back(bank * 2048 + idx);
        bus.en_in = 1'b1;
        din       = data[15:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Block data base+j was written row-major at offset j; reads come out column-major.
    task automatic push_reads(input int bank, input int base);
        for (int k = 0; k < BLK; k++) begin
            int off;
            off = (k % ROWS) * COLS + (k / ROWS);
            exp_ra.push_back(bank * 2048 + off);
            exp_rd.push_back(base + off);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.en_in = 1'b1;
        din       = '0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_nce", int'(bus.NCE), 1);
        chk("rst_nwrt", int'(bus.NWRT), 1);
        chk("rst_addr", int'(bus.ADDR), 0);
        chk("rst_en_out", int'(bus.en_out), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_state", int'(dut.state_reg), int'(ST_FILL));
        chk("rst_bank_r", int'(dut.bank_r_reg), 1);
        @(posedge clk);
        #1;
        bus.en_in = 1'b0;
        rst       = 1'b1;
        idle();

        // Fill bank 0 at half rate, no reads expected.
        for (int j = 0; j < BLK; j++) begin
            wr(0, j, j);
            if (j == BLK - 1) push_reads(0, 0);
            idle();
        end
        chk("fill_state", int'(dut.state_reg), int'(ST_RUN));
        chk("fill_bank_r", int'(dut.bank_r_reg), 0);

        // Second block into bank 1 while bank 0 drains column-major.
        for (int j = 0; j < BLK; j++) begin
            wr(1, j, BLK + j);
            if (j == BLK - 1) push_reads(1, BLK);
            idle();
        end
        chk("blk2_state", int'(dut.state_reg), int'(ST_RUN));
        chk("blk2_bank_r", int'(dut.bank_r_reg), 1);
        chk("blk2_err", int'(bus.err), 0);

        // Input stops; bank 1 drains then the scheduler parks in WAIT.
        n = 0;
        while (dut.state_reg != ST_WAIT && n < 4000) begin
            idle();
            n++;
        end
        chk("drain_state", int'(dut.state_reg), int'(ST_WAIT));
        chk("drain_last_addr", last_raddr, 3583);
        repeat (4) idle();
        chk("drain_rd_left", exp_ra.size(), 0);

        // Back-to-back input: err on first pair, then overrun into HOLD.
        wr(0, 0, 2 * BLK);
        chk("b2b_err_first", int'(bus.err), 0);
        wr(0, 1, 2 * BLK + 1);
        chk("b2b_err_pair", int'(bus.err), 1);
        for (int j = 2; j < BLK; j++) wr(0, j, 2 * BLK + j);
        push_reads(0, 2 * BLK);
        chk("wait_swap_state", int'(dut.state_reg), int'(ST_RUN));
        chk("wait_swap_bank_r", int'(dut.bank_r_reg), 0);
        for (int j = 0; j < BLK; j++) wr(1, j, 3 * BLK + j);
        push_reads(1, 3 * BLK);
        chk("hold_state", int'(dut.state_reg), int'(ST_HOLD));
        for (int i = 0; i < 3; i++) begin
            bus.en_in = 1'b1;
            din       = 16'hdead;
            #1;
            chk("hold_drop_nce", int'(bus.NCE), 1);
            @(posedge clk);
            #1;
        end
        n = 0;
        while (dut.state_reg != ST_RUN && n < 2000) begin
            idle();
            n++;
        end
        chk("hold_exit_state", int'(dut.state_reg), int'(ST_RUN));
        chk("hold_exit_bank_r", int'(dut.bank_r_reg), 1);

        // Partial block, then a one-cycle reset discards everything.
        for (int j = 0; j < 700; j++) begin
            wr(0, j, 7000 + j);
            idle();
        end
        chk("pre_rst_wcnt", int'(dut.wcnt_reg), 700);
        bus.en_in = 1'b1;
        rst       = 1'b0;
        #1;
        chk("mid_rst_nce", int'(bus.NCE), 1);
        chk("mid_rst_nwrt", int'(bus.NWRT), 1);
        chk("mid_rst_addr", int'(bus.ADDR), 0);
        chk("mid_rst_en_out", int'(bus.en_out), 0);
        chk("mid_rst_err", int'(bus.err), 0);
        chk("mid_rst_state", int'(dut.state_reg), int'(ST_FILL));
        exp_w.delete();
        exp_ra.delete();
        exp_rd.delete();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.en_in = 1'b0;
        chk("post_rst_bank_r", int'(dut.bank_r_reg), 1);
        for (int j = 0; j < 4; j++) begin
            wr(0, j, j);
            idle();
        end
        chk("refill_state", int'(dut.state_reg), int'(ST_FILL));
        repeat (3) idle();
        chk("end_w_left", exp_w.size(), 0);
        chk("end_ra_left", exp_ra.size(), 0);
        chk("end_rd_left", exp_rd.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
